// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - uart_state_e : receiver frame states
//   - UART_CLK_FREQ / UART_BAUD / UART_OVERSAMPLE : default line setup
//   - uart_div()   : prescaler divide ratio, also used by the transmitter
//   - uart_maj3()  : 2-of-3 vote used when UART_RX_MAJORITY_EN is defined
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_CLK_FREQ   = 32'd100000000;
  localparam int unsigned UART_BAUD       = 32'd250000;
  localparam int unsigned UART_OVERSAMPLE = 32'd16;

  // Clocks per oversample tick (integer division, 25 at the defaults).
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

  // Majority of three samples.
  function automatic logic uart_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample prescaler.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear, holds the count at zero
//   tick  : registered one-clock pulse every DIV clocks after clr drops
module uart_baud_tick
  #(
    parameter int unsigned DIV = 32'd25
  ) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
  );

  localparam int unsigned   CW   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count; tick is registered so it is high exactly while cnt_q == LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(32'd1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver with valid/ready output.
//   CLK     : system clock (rising edge)
//   RST_N   : asynchronous active-low reset
//   RX      : serial input, asynchronous, idle high
//   DATA    : received byte, stable while VALID=1
//   VALID   : DATA holds an unconsumed byte
//   READY   : consumer takes DATA when VALID && READY
//   FERR    : one-clock pulse, stop bit sampled low
//   OVERRUN : one-clock pulse, byte dropped because VALID was still set
//   BUSY    : receiver is inside a frame
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 vote around mid-bit,
// all decisions one tick later).
module uart_receiver
  import uart_pkg::*;
  #(
    parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
    parameter int unsigned BAUD       = UART_BAUD,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
  ) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FERR,
    output logic       OVERRUN,
    output logic       BUSY
  );

  localparam int unsigned   DIV       = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned   TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 32'd1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] EARLY_CNT  = TW'(OVERSAMPLE / 32'd2 - 32'd2);
  localparam logic [TW-1:0] MID_CNT    = TW'(OVERSAMPLE / 32'd2 - 32'd1);
  localparam logic [TW-1:0] DECIDE_CNT = TW'(OVERSAMPLE / 32'd2);
`else
  localparam logic [TW-1:0] DECIDE_CNT = TW'(OVERSAMPLE / 32'd2 - 32'd1);
`endif

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  uart_state_e   state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d, stop_bit_q, stop_bit_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, busy_q, busy_d;
  logic          tick_s, clr_s, fall_s, decide_s, bit_s, hs_s;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]    hist_q, hist_d;
`endif

  // Prescaler is held clear while idle, so its phase starts at detection.
  assign clr_s = (state_q == ST_IDLE);

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Edge detect and per-bit decision point.
  always_comb begin
    fall_s = prev_q & ~sync2_q;
`ifdef UART_RX_MAJORITY_EN
    hist_d = hist_q;
    if (tick_s && (tcnt_q == EARLY_CNT)) begin
      hist_d[1] = sync2_q;
    end else if (tick_s && (tcnt_q == MID_CNT)) begin
      hist_d[0] = sync2_q;
    end else begin
      hist_d = hist_q;
    end
    decide_s = tick_s && (tcnt_q == DECIDE_CNT);
    bit_s    = uart_maj3(hist_q[1], hist_q[0], sync2_q);
`else
    decide_s = tick_s && (tcnt_q == DECIDE_CNT);
    bit_s    = sync2_q;
`endif
  end

  // Synchronizer, frame FSM next state and shift register.
  always_comb begin
    sync1_d    = RX;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    stop_bit_d = stop_bit_q;

    // Tick counter runs modulo OVERSAMPLE from detection, so mid-bit of every
    // bit lands on the same count value.
    if (state_q == ST_IDLE) begin
      tcnt_d = '0;
    end else if (tick_s) begin
      tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + TW'(32'd1);
    end else begin
      tcnt_d = tcnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (decide_s && bit_s) begin
          state_d = ST_IDLE;          // glitch, not a start bit
        end else if (decide_s) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s) begin
          shift_d[idx_q] = bit_s;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (decide_s) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          stop_bit_d = bit_s;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output stage: acts one clock after the stop decision.
  always_comb begin
    hs_s    = valid_q & READY;
    data_d  = data_q;
    valid_d = valid_q & ~hs_s;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (done_q && !stop_bit_q) begin
      ferr_d = 1'b1;
    end else if (done_q && (!valid_q || hs_s)) begin
      // A handshake in the same cycle frees the slot for the new byte.
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (done_q) begin
      ovr_d = 1'b1;
    end else begin
      data_d = data_q;
    end
    busy_d = (state_q != ST_IDLE);
  end

  // All receiver registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'd0;
      done_q     <= 1'b0;
      stop_bit_q <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q     <= 2'b00;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      stop_bit_q <= stop_bit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q     <= hist_d;
`endif
    end
  end

  assign DATA    = data_q;
  assign VALID   = valid_q;
  assign FERR    = ferr_q;
  assign OVERRUN = ovr_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level reference model plus directed frames for
// uart_receiver at 100 MHz / 250000 baud / 16x oversampling.
module tb_uart_receiver;

  localparam int unsigned DIV = 32'd25;
  localparam int unsigned OS  = 32'd16;
  localparam int unsigned BIT = OS * DIV;   // clocks per bit
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MAJ_OFF = DIV;
`else
  localparam int unsigned MAJ_OFF = 32'd0;
`endif
  // Line fall -> registered output: 3 sync clocks, stop mid-bit, 1 output clock.
  localparam int unsigned M_LAT    = 32'd3 + (OS / 32'd2 + 32'd9 * OS) * DIV + 32'd1 + MAJ_OFF;
  localparam int unsigned M_GL_END = 32'd3 + (OS / 32'd2) * DIV + 32'd1 + MAJ_OFF;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       RX    = 1'b1;
  logic       READY = 1'b0;
  logic [7:0] DATA;
  logic       VALID, FERR, OVERRUN, BUSY;

  uart_receiver #(
    .CLK_FREQ   (32'd100000000),
    .BAUD       (32'd250000),
    .OVERSAMPLE (32'd16)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RX      (RX),
    .DATA    (DATA),
    .VALID   (VALID),
    .READY   (READY),
    .FERR    (FERR),
    .OVERRUN (OVERRUN),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct { int unsigned at; logic [7:0] d; logic ok; } ev_t;
  typedef struct { int unsigned lo; int unsigned hi; } win_t;

  ev_t         evq[$];
  win_t        winq[$];
  int unsigned cyc = 0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_data  = 8'd0;
  logic        m_ferr  = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_hs;
  ev_t         m_e;

  int n_checks = 0;
  int n_errors = 0;

  // Observations of the DUT used by the directed checks.
  int unsigned vrise_cnt = 0, vrise_cyc = 0, vhigh_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, bfall_cyc = 0;
  logic [7:0]  vrise_data = 8'd0;
  logic        last_valid = 1'b0, last_busy = 1'b0;

  // Frame-level model: each frame resolves into one output event at its due cycle.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (!RST_N) begin
      m_valid = 1'b0; m_data = 8'd0; m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      evq.delete();
      winq.delete();
    end else begin
      m_hs   = m_valid && READY;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (m_hs) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        m_e = evq.pop_front();
        if (!m_e.ok) m_ferr = 1'b1;
        else if (!m_valid) begin m_data = m_e.d; m_valid = 1'b1; end
        else m_ovr = 1'b1;
      end
      while (winq.size() > 0 && cyc >= winq[0].hi) void'(winq.pop_front());
      m_busy = (winq.size() > 0) && (cyc >= winq[0].lo);
    end
  end

  // Every-cycle comparison against the model, plus observation bookkeeping.
  always @(negedge CLK) begin
    if (RST_N) begin
      n_checks = n_checks + 1;
      if ({VALID, DATA, FERR, OVERRUN, BUSY} !== {m_valid, m_data, m_ferr, m_ovr, m_busy}) begin
        n_errors = n_errors + 1;
        $display("FAIL model_cmp cyc=%0d: dut v=%b d=%h ferr=%b ovr=%b busy=%b required v=%b d=%h ferr=%b ovr=%b busy=%b",
                 cyc, VALID, DATA, FERR, OVERRUN, BUSY, m_valid, m_data, m_ferr, m_ovr, m_busy);
      end
      if (VALID && !last_valid) begin
        vrise_cnt  = vrise_cnt + 1;
        vrise_cyc  = cyc;
        vrise_data = DATA;
      end
      if (VALID)   vhigh_cnt = vhigh_cnt + 1;
      if (FERR)    ferr_cnt  = ferr_cnt + 1;
      if (OVERRUN) ovr_cnt   = ovr_cnt + 1;
      if (!BUSY && last_busy) bfall_cyc = cyc;
      last_valid = VALID;
      last_busy  = BUSY;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    vrise_cnt = 0; vrise_cyc = 0; vhigh_cnt = 0; ferr_cnt = 0; ovr_cnt = 0; bfall_cyc = 0;
    vrise_data = 8'd0;
  endtask

  // Drives one 10-bit frame starting now (called just after a rising edge).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic spikes,
                            output int unsigned c0);
    logic b;
    c0 = cyc;
    evq.push_back('{at: c0 + M_LAT, d: d, ok: stop_v});
    winq.push_back('{lo: c0 + 32'd4, hi: c0 + M_LAT});
    for (int i = 0; i < int'(10 * BIT); i++) begin
      if (i < int'(BIT)) b = 1'b0;
      else if (i < int'(9 * BIT)) b = d[(i - int'(BIT)) / int'(BIT)];
      else b = stop_v;
      if (spikes) begin
        for (int k = 0; k < 8; k++) begin
          if (i == int'(BIT / 2 + BIT * (k + 1))) b = ~b;
        end
      end
      RX = b;
      @(posedge CLK);
      #1;
    end
    RX = 1'b1;
  endtask

  int unsigned c;

  initial begin
    // Reset state.
    idle(5);
    check("rst_valid", VALID, 32'd0);
    check("rst_data", DATA, 32'd0);
    check("rst_ferr", FERR, 32'd0);
    check("rst_overrun", OVERRUN, 32'd0);
    check("rst_busy", BUSY, 32'd0);
    RST_N = 1'b1;
    idle(20);

    // 0xA5 with READY held high.
    READY = 1'b1;
    clear_obs();
    send_frame(8'hA5, 1'b1, 1'b0, c);
    idle(200);
    check("a5_rise_count", vrise_cnt, 32'd1);
    check("a5_latency", vrise_cyc - c, 32'd3804 + MAJ_OFF);
    check("a5_data", vrise_data, 32'hA5);
    check("a5_valid_cycles", vhigh_cnt, 32'd1);
    check("a5_ferr", ferr_cnt, 32'd0);
    check("a5_overrun", ovr_cnt, 32'd0);

    // 100-clock low glitch on an idle line.
    clear_obs();
    c = cyc;
    RX = 1'b0;
    winq.push_back('{lo: c + 32'd4, hi: c + M_GL_END});
    idle(100);
    RX = 1'b1;
    idle(400);
    check("glitch_valid", vrise_cnt, 32'd0);
    check("glitch_ferr", ferr_cnt, 32'd0);
    check("glitch_busy_fall", (bfall_cyc > c) && (bfall_cyc - c <= 32'd210 + MAJ_OFF), 32'd1);

    // Stop bit forced low, then a clean frame.
    clear_obs();
    send_frame(8'h3C, 1'b0, 1'b0, c);
    idle(400);
    check("ferr_pulses", ferr_cnt, 32'd1);
    check("ferr_no_valid", vrise_cnt, 32'd0);
    clear_obs();
    send_frame(8'h55, 1'b1, 1'b0, c);
    idle(200);
    check("after_ferr_data", vrise_data, 32'h55);
    check("after_ferr_rise", vrise_cnt, 32'd1);

    // Back-to-back frames with no consumer.
    READY = 1'b0;
    clear_obs();
    send_frame(8'h11, 1'b1, 1'b0, c);
    send_frame(8'h22, 1'b1, 1'b0, c);
    idle(200);
    check("ovr_data_held", DATA, 32'h11);
    check("ovr_valid_held", VALID, 32'd1);
    check("ovr_pulses", ovr_cnt, 32'd1);
    READY = 1'b1;
    idle(1);
    check("ovr_valid_cleared", VALID, 32'd0);
    check("ovr_data_after", DATA, 32'h11);

    // Reset mid-frame with the line held low afterwards.
    clear_obs();
    c = cyc;
    RX = 1'b0;
    winq.push_back('{lo: c + 32'd4, hi: c + M_LAT});
    idle(100);
    check("midrst_busy_before", BUSY, 32'd1);
    RST_N = 1'b0;
    idle(5);
    RST_N = 1'b1;
    idle(int'(2 * BIT));
    check("midrst_no_start", BUSY, 32'd0);
    check("midrst_no_valid", vrise_cnt, 32'd0);
    RX = 1'b1;
    idle(400);
    send_frame(8'h0F, 1'b1, 1'b0, c);
    idle(200);
    check("midrst_next_data", vrise_data, 32'h0F);
    check("midrst_next_rise", vrise_cnt, 32'd1);

`ifdef UART_RX_MAJORITY_EN
    // One-clock spikes at each data-bit mid-sample are outvoted.
    clear_obs();
    send_frame(8'h00, 1'b1, 1'b1, c);
    idle(200);
    check("maj_data", vrise_data, 32'h00);
    check("maj_rise", vrise_cnt, 32'd1);
    check("maj_ferr", ferr_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
